// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, frame-granular enable,
// and a two-stage output pipeline that fetches pixels from a read FIFO.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  output logic        data_req,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [15:0] rgb_out,
  output logic        frame_start,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT       = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT       = 12'(V_ACTIVE);
  localparam logic [11:0] H_ACT_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HS_START    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END      = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END      = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        pend;
  logic        frame_en;

  logic        boundary;
  logic        in_active;
  logic        in_hsync;
  logic        in_vsync;
  logic        at_first;
  logic        at_last;

  logic        hsync_s1;
  logic        vsync_s1;
  logic        first_s1;
  logic        last_s1;
  logic        last_s2;

  always_comb begin
    boundary  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    in_hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    in_vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    at_first  = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    at_last   = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 12'd0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // An enable seen in the boundary clock itself still lands in the next frame.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      pend     <= 1'b0;
      frame_en <= 1'b0;
    end else if (boundary) begin
      frame_en <= pend | enable;
      pend     <= 1'b0;
    end else begin
      pend     <= pend | enable;
    end
  end

  // Stage 1: FIFO read strobe plus region flags (sync kept as "in sync", polarity applied later).
  always_ff @(posedge video_clk) begin
    if (rst) begin
      data_req <= 1'b0;
      hsync_s1 <= 1'b0;
      vsync_s1 <= 1'b0;
      first_s1 <= 1'b0;
      last_s1  <= 1'b0;
    end else begin
      data_req <= frame_en & in_active;
      hsync_s1 <= in_hsync;
      vsync_s1 <= in_vsync;
      first_s1 <= frame_en & at_first;
      last_s1  <= frame_en & at_last;
    end
  end

  // Stage 2: visible outputs; the FIFO word arrives while data_req is high.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      rgb_out     <= 16'd0;
      frame_start <= 1'b0;
      last_s2     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      de          <= data_req;
      hs          <= hsync_s1 ? HS_POL : ~HS_POL;
      vs          <= vsync_s1 ? VS_POL : ~VS_POL;
      rgb_out     <= data_req ? data_in : 16'd0;
      frame_start <= first_s1;
      last_s2     <= last_s1;
      frame_done  <= last_s2;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 8x6 raster (48-clock frame), active-low syncs,
// checked every cycle against a frame-level model.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic        video_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        data_req, hs, vs, de, frame_start, frame_done;
  logic [15:0] rgb_out;

  always #5 video_clk = ~video_clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .video_clk(video_clk),
    .rst(rst),
    .enable(enable),
    .data_in(data_in),
    .data_req(data_req),
    .hs(hs),
    .vs(vs),
    .de(de),
    .rgb_out(rgb_out),
    .frame_start(frame_start),
    .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  // Model state: t = counter position (clocks since reset), frames flagged as enabled.
  int          t = 0;
  bit          model_valid = 1'b0;
  bit          en_frame [0:255];
  logic [15:0] din_hist [0:4095];

  int n_hs_low, n_vs_low, n_de, n_dreq, n_fs, n_fd;

  function automatic int hh(input int tt);
    return tt % HT;
  endfunction

  function automatic int vv(input int tt);
    return (tt / HT) % VT;
  endfunction

  function automatic bit fen(input int tt);
    return en_frame[tt / FT];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  // Input driver: fresh pixel word every clock.
  initial forever begin
    @(posedge video_clk);
    #1 data_in = 16'($urandom);
  end

  // Model update: an enable during frame f enables frame f+1; reset forgets everything.
  initial forever begin
    @(posedge video_clk);
    if (rst) begin
      t = 0;
      for (int i = 0; i < 256; i++) en_frame[i] = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (enable) en_frame[t / FT + 1] = 1'b1;
      if (t < 4096) din_hist[t] = data_in;
      t = t + 1;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic exp_hs, exp_vs, exp_de, exp_dr, exp_fs, exp_fd;
    logic [15:0] exp_rgb;
    forever begin
      @(negedge video_clk);
      if (model_valid) begin
        exp_hs = !(t >= 2 && hh(t-2) >= HA+HF && hh(t-2) < HA+HF+HSY);
        exp_vs = !(t >= 2 && vv(t-2) >= VA+VF && vv(t-2) < VA+VF+VSY);
        exp_de = (t >= 2) && fen(t-2) && hh(t-2) < HA && vv(t-2) < VA;
        exp_dr = (t >= 1) && fen(t-1) && hh(t-1) < HA && vv(t-1) < VA;
        exp_rgb = exp_de ? din_hist[t-1] : 16'd0;
        exp_fs = (t >= 2) && fen(t-2) && hh(t-2) == 0 && vv(t-2) == 0;
        exp_fd = (t >= 3) && fen(t-3) && hh(t-3) == HA-1 && vv(t-3) == VA-1;
        chk("hs", 16'(hs), 16'(exp_hs));
        chk("vs", 16'(vs), 16'(exp_vs));
        chk("de", 16'(de), 16'(exp_de));
        chk("data_req", 16'(data_req), 16'(exp_dr));
        chk("rgb_out", rgb_out, exp_rgb);
        chk("frame_start", 16'(frame_start), 16'(exp_fs));
        chk("frame_done", 16'(frame_done), 16'(exp_fd));
        if (hs === 1'b0) n_hs_low++;
        if (vs === 1'b0) n_vs_low++;
        if (de === 1'b1) n_de++;
        if (data_req === 1'b1) n_dreq++;
        if (frame_start === 1'b1) n_fs++;
        if (frame_done === 1'b1) n_fd++;
      end
    end
  end

  task automatic step();
    @(posedge video_clk);
    #1;
  endtask

  task automatic zero_counts();
    n_hs_low = 0; n_vs_low = 0; n_de = 0; n_dreq = 0; n_fs = 0; n_fd = 0;
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (t == target) return;
      step();
    end
    chk("wait_t_timeout", 16'(t), 16'(target));
  endtask

  task automatic wait_hv(input int h, input int v);
    for (int i = 0; i < 200; i++) begin
      step();
      if (hh(t) == h && vv(t) == v) return;
    end
    chk("wait_hv_timeout", 16'(hh(t)), 16'(h));
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  initial begin
    zero_counts();
    repeat (3) step();
    rst = 1'b0;

    // Idle: two frames, no enable.
    wait_t(2);
    zero_counts();
    wait_t(98);
    chk("idle_hs_low", 16'(n_hs_low), 16'd24);
    chk("idle_vs_low", 16'(n_vs_low), 16'd16);
    chk("idle_de", 16'(n_de), 16'd0);
    chk("idle_dreq", 16'(n_dreq), 16'd0);
    $display("idle: hs_low=%0d vs_low=%0d de=%0d", n_hs_low, n_vs_low, n_de);

    // Single-clock enable at h=3,v=1 of frame 2 -> frame 3 enabled, frame 4 blank.
    wait_hv(3, 1);
    pulse_enable();
    wait_t(144);
    zero_counts();
    wait_t(146);
    @(negedge video_clk);
    chk("first_de", 16'(de), 16'd1);
    chk("first_fs", 16'(frame_start), 16'd1);
    chk("first_rgb", rgb_out, din_hist[145]);
    wait_t(240);
    chk("single_de", 16'(n_de), 16'd12);
    chk("single_dreq", 16'(n_dreq), 16'd12);
    chk("single_fs", 16'(n_fs), 16'd1);
    chk("single_fd", 16'(n_fd), 16'd1);
    $display("single: de=%0d dreq=%0d fs=%0d fd=%0d", n_de, n_dreq, n_fs, n_fd);

    // Enable exactly in the boundary clock of frame 5 -> frame 6 enabled.
    wait_hv(HT-1, VT-1);
    pulse_enable();
    wait_t(288);
    zero_counts();
    wait_t(339);
    chk("race_de", 16'(n_de), 16'd12);
    chk("race_fs", 16'(n_fs), 16'd1);
    chk("race_fd", 16'(n_fd), 16'd1);
    $display("boundary: de=%0d fs=%0d fd=%0d", n_de, n_fs, n_fd);

    // Continuous enable: three consecutive frames fully populated.
    enable = 1'b1;
    wait_t(386);
    zero_counts();
    wait_t(530);
    chk("cont_de", 16'(n_de), 16'd36);
    chk("cont_dreq", 16'(n_dreq), 16'd36);
    chk("cont_fs", 16'(n_fs), 16'd3);
    chk("cont_fd", 16'(n_fd), 16'd3);
    $display("continuous: de=%0d dreq=%0d fs=%0d fd=%0d", n_de, n_dreq, n_fs, n_fd);

    // Reset at h=2,v=1 of an enabled frame with a further enable already pending.
    enable = 1'b0;
    wait_hv(2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge video_clk);
    chk("rst_de", 16'(de), 16'd0);
    chk("rst_hs", 16'(hs), 16'd1);
    chk("rst_vs", 16'(vs), 16'd1);
    chk("rst_dreq", 16'(data_req), 16'd0);
    chk("rst_rgb", rgb_out, 16'd0);
    wait_t(2);
    zero_counts();
    wait_t(98);
    chk("post_rst_de", 16'(n_de), 16'd0);
    chk("post_rst_hs_low", 16'(n_hs_low), 16'd24);
    $display("reset: de=%0d hs_low=%0d", n_de, n_hs_low);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 40, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, default 220, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 5, 5 and 20, vertical porch and sync widths in lines.
REQ-007 SHALL have parameters HS_POL and VS_POL, default 1, giving the active level of hs and vs.
REQ-008 SHALL have port video_clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-010 SHALL have port enable, input, 1, frame-output request, synchronous to video_clk.
REQ-011 SHALL have port data_in, input, 16, RGB565 pixel from the read FIFO, valid 1 clock after data_req.
REQ-012 SHALL have port data_req, output, 1, pixel FIFO read strobe.
REQ-013 SHALL have ports hs, vs and de, output, 1 each, sync and data-enable.
REQ-014 SHALL have port rgb_out, output, 16, pixel aligned with de.
REQ-015 SHALL have ports frame_start and frame_done, output, 1 each, single-clock status pulses.

Function
REQ-016 SHALL run counter h_cnt over 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; wraps to 0.
REQ-017 SHALL advance v_cnt over 0..V_TOTAL-1 only when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
REQ-018 SHALL order regions as active, front porch, sync, back porch, with count 0 as the first active pixel or line.
REQ-019 SHALL use 12-bit counters; H_TOTAL and V_TOTAL SHALL not exceed 4096; no other overflow handling.
REQ-020 SHALL keep the counters free-running whatever enable does; hs and vs SHALL always toggle.
REQ-021 SHALL set sticky flag pend on any clock where enable is 1.
REQ-022 SHALL sample pend into frame_en at the frame boundary (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1), then clear pend, in that clock.
REQ-023 SHALL let an enable that arrives in the boundary clock itself count toward that boundary.
REQ-024 SHALL hold an enable that arrives mid-frame pending for the next frame; the frame in progress is unchanged.
REQ-025 SHALL hold frame_en through the whole frame; frame_en=0 means blank frame: de, data_req, frame_start and frame_done stay 0 and rgb_out stays 0.
REQ-026 SHALL assert data_req 1 clock after counters sit in the active region (h<H_ACTIVE, v<V_ACTIVE) with frame_en=1.
REQ-027 SHALL assert de, hs and vs 2 clocks after the counter condition that produces them.
REQ-028 SHALL set rgb_out to data_in, registered, when the delayed data_req is 1, and to 0 otherwise; rgb_out aligns with de.
REQ-029 SHALL drive hs = HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), otherwise !HS_POL.
REQ-030 SHALL drive vs = VS_POL when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), otherwise !VS_POL.
REQ-031 SHALL pulse frame_start 1 clock, together with the first de of an enabled frame.
REQ-032 SHALL pulse frame_done 1 clock, 1 clock after the last de of an enabled frame.
REQ-033 SHALL make every output a register output.

Reset
REQ-034 SHALL, on rst, clear h_cnt, v_cnt, pend, frame_en and all pipeline stages to 0.
REQ-035 SHALL, on rst, force hs=!HS_POL, vs=!VS_POL, de=0, data_req=0, rgb_out=0, frame_start=0 and frame_done=0.
REQ-036 SHALL let rst mid-frame abort the frame, drop any pending enable, and restart timing from h_cnt=0, v_cnt=0 with frame_en=0.

Verification
REQ-037 SHALL be verified with a small config: H 4/1/2/1 (total 8) and V 3/1/1/1 (total 6), i.e. a 48-clock frame.
REQ-038 SHALL be checked for idle timing: no enable -> hs low 2 of every 8 clocks, vs low 8 of every 48 clocks, de and data_req never 1.
REQ-039 SHALL be checked for a single-frame pulse: enable for 1 clock at h=3,v=1 -> next frame has 12 de clocks, rgb_out equal to data_in from 1 clock earlier, frame_start with the first de, frame_done 1 clock after the last de, and the frame after that blank.
REQ-040 SHALL be checked for the boundary race: enable in the boundary clock (h=7,v=5) -> the immediately following frame is enabled.
REQ-041 SHALL be checked for continuous enable: enable held high -> every frame enabled, 12 data_req and 12 de per frame, no gaps between frames.
REQ-042 SHALL be checked for reset mid-frame: rst for 1 clock at h=2,v=1 of an enabled frame -> all outputs at reset values the next clock, counters restart at 0, and the next frame is blank unless enable arrives again.
